// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - multi-channel button synchronizer and debouncer
// Optional macro BUTTON_DEBOUNCE_PULSE_EN adds btn_prs/btn_rls edge pulse outputs.
module button_debounce #(
  parameter int BTN = 3,
  parameter int DBN = 5,
  parameter int SYN = 2,
  parameter int POL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BTN-1:0] btn_raw,
  output logic [BTN-1:0] btn_deb
`ifdef BUTTON_DEBOUNCE_PULSE_EN
  ,
  output logic [BTN-1:0] btn_prs,
  output logic [BTN-1:0] btn_rls
`endif
);

  localparam int DBL = $clog2(DBN + 1);
  localparam logic [DBL-1:0] CNT_LAST = DBL'(DBN - 1);

  // Inactive level is 0 after this point, so every reset value below is 0.
  logic [BTN-1:0] eff_in;
  logic [BTN-1:0] sync_q [SYN];
  logic [BTN-1:0] sync_d [SYN];
  logic [DBL-1:0] cnt_q  [BTN];
  logic [DBL-1:0] cnt_d  [BTN];
  logic [BTN-1:0] btn_deb_q, btn_deb_d;
  logic [BTN-1:0] samp;

  assign eff_in = (POL != 0) ? btn_raw : ~btn_raw;
  assign samp   = sync_q[SYN-1];

  // Plain shift chain; nothing between stages so metastability can settle.
  always_comb begin
    sync_d[0] = eff_in;
    for (int i = 1; i < SYN; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Per-channel stability count; any agreeing sample throws away progress.
  always_comb begin
    btn_deb_d = btn_deb_q;
    for (int ch = 0; ch < BTN; ch++) begin
      cnt_d[ch] = '0;
      if (samp[ch] != btn_deb_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          btn_deb_d[ch] = samp[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + DBL'(1);
        end
      end
    end
  end

  // State registers for synchronizers, counters and debounced levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYN; i++) sync_q[i] <= '0;
      for (int ch = 0; ch < BTN; ch++) cnt_q[ch] <= '0;
      btn_deb_q <= '0;
    end else begin
      for (int i = 0; i < SYN; i++) sync_q[i] <= sync_d[i];
      for (int ch = 0; ch < BTN; ch++) cnt_q[ch] <= cnt_d[ch];
      btn_deb_q <= btn_deb_d;
    end
  end

  assign btn_deb = btn_deb_q;

`ifdef BUTTON_DEBOUNCE_PULSE_EN
  logic [BTN-1:0] btn_prs_q, btn_prs_d;
  logic [BTN-1:0] btn_rls_q, btn_rls_d;

  // Pulses come from the same next-state as btn_deb so they land in its update cycle.
  always_comb begin
    btn_prs_d = btn_deb_d & ~btn_deb_q;
    btn_rls_d = ~btn_deb_d & btn_deb_q;
  end

  // Registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prs_q <= '0;
      btn_rls_q <= '0;
    end else begin
      btn_prs_q <= btn_prs_d;
      btn_rls_q <= btn_rls_d;
    end
  end

  assign btn_prs = btn_prs_q;
  assign btn_rls = btn_rls_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - randomized and directed bench for button_debounce
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw, raw_lo;
  logic [2:0] deb, deb_lo;
`ifdef BUTTON_DEBOUNCE_PULSE_EN
  logic [2:0] prs, rls, prs_lo, rls_lo;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  button_debounce dut (
    .clk(clk), .rst(rst), .btn_raw(raw), .btn_deb(deb)
`ifdef BUTTON_DEBOUNCE_PULSE_EN
    , .btn_prs(prs), .btn_rls(rls)
`endif
  );

  button_debounce #(.BTN(3), .DBN(1), .SYN(2), .POL(0)) dut_lo (
    .clk(clk), .rst(rst), .btn_raw(raw_lo), .btn_deb(deb_lo)
`ifdef BUTTON_DEBOUNCE_PULSE_EN
    , .btn_prs(prs_lo), .btn_rls(rls_lo)
`endif
  );

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: the output flips once the last DBN synchronized samples
  // (history entries SYN-1 .. SYN+DBN-2 ago) all disagree with it.
  logic [2:0] h_a [16];
  logic [2:0] h_b [16];
  logic [2:0] m_deb = '0, m_prs = '0, m_rls = '0;
  logic [2:0] l_deb = '0, l_prs = '0, l_rls = '0;
  logic [2:0] nd;
  bit         armed = 1'b0;

  function automatic logic [2:0] flips(input logic [2:0] h [16], input int syn,
                                       input int dbn, input logic [2:0] cur);
    logic [2:0] f;
    f = 3'b111;
    for (int k = syn - 1; k <= syn + dbn - 2; k++) f &= h[k] ^ cur;
    return f;
  endfunction

  always @(posedge clk) begin
    armed = 1'b1;
    if (rst) begin
      m_deb = '0; m_prs = '0; m_rls = '0;
      l_deb = '0; l_prs = '0; l_rls = '0;
      for (int k = 0; k < 16; k++) begin
        h_a[k] = '0;
        h_b[k] = '0;
      end
    end else begin
      nd    = m_deb ^ flips(h_a, 2, 5, m_deb);
      m_prs = nd & ~m_deb;
      m_rls = ~nd & m_deb;
      m_deb = nd;
      nd    = l_deb ^ flips(h_b, 2, 1, l_deb);
      l_prs = nd & ~l_deb;
      l_rls = ~nd & l_deb;
      l_deb = nd;
      for (int k = 15; k > 0; k--) begin
        h_a[k] = h_a[k-1];
        h_b[k] = h_b[k-1];
      end
      h_a[0] = raw;
      h_b[0] = ~raw_lo;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("model_deb", deb, m_deb);
      chk("model_deb_lo", deb_lo, l_deb);
`ifdef BUTTON_DEBOUNCE_PULSE_EN
      chk("model_prs", prs, m_prs);
      chk("model_rls", rls, m_rls);
      chk("model_prs_lo", prs_lo, l_prs);
      chk("model_rls_lo", rls_lo, l_rls);
`endif
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; raw = 3'b000; raw_lo = 3'b111;
    edges(2);
    chk("reset_deb", deb, 3'b000);
    chk("reset_deb_lo", deb_lo, 3'b000);
    @(negedge clk); rst = 1'b0;
    edges(4);
    chk("idle_lo", deb_lo, 3'b000);

    // Clean press on bit0: update on the 7th edge.
    @(negedge clk); raw = 3'b001;
    edges(6);
    chk("press_edge6", deb, 3'b000);
    edges(1);
    chk("press_edge7", deb, 3'b001);
`ifdef BUTTON_DEBOUNCE_PULSE_EN
    chk("press_pulse", prs, 3'b001);
    edges(1);
    chk("press_pulse_end", prs, 3'b000);
`endif

    // Glitch on bit1: 4 cycles high is never enough.
    @(negedge clk); raw = 3'b011;
    repeat (4) @(negedge clk);
    raw = 3'b001;
    edges(12);
    chk("glitch_reject", deb, 3'b001);
    @(negedge clk); raw = 3'b011;
    edges(6);
    chk("glitch_hold_edge6", deb, 3'b001);
    edges(1);
    chk("glitch_hold_edge7", deb, 3'b011);

    // Bouncing release on bit2.
    @(negedge clk); raw = 3'b111;
    edges(10);
    chk("bit2_set", deb, 3'b111);
    @(negedge clk); raw = 3'b011;
    @(negedge clk); raw = 3'b111;
    @(negedge clk); raw = 3'b011;
    @(negedge clk); raw = 3'b111;
    @(negedge clk); raw = 3'b011;
    edges(6);
    chk("bounce_edge6", deb, 3'b111);
    edges(1);
    chk("bounce_edge7", deb, 3'b011);

    // Simultaneous rise on all channels.
    @(negedge clk); raw = 3'b000;
    edges(10);
    chk("all_low", deb, 3'b000);
    @(negedge clk); raw = 3'b111;
    edges(6);
    chk("simul_edge6", deb, 3'b000);
    edges(1);
    chk("simul_edge7", deb, 3'b111);

    // Reset while bit0 held.
    @(negedge clk); raw = 3'b001;
    edges(10);
    chk("held_before_rst", deb, 3'b001);
    @(negedge clk); rst = 1'b1;
    edges(1);
    chk("rst_first_edge", deb, 3'b000);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    edges(6);
    chk("post_rst_edge6", deb, 3'b000);
    edges(1);
    chk("post_rst_edge7", deb, 3'b001);

    // Active-low instance with DBN=1.
    @(negedge clk); raw_lo = 3'b110;
    edges(2);
    chk("lo_edge2", deb_lo, 3'b000);
    edges(1);
    chk("lo_edge3", deb_lo, 3'b001);

    // Random levels with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 6) == 0) raw[b] = ~raw[b];
        if ($urandom_range(0, 3) == 0) raw_lo[b] = ~raw_lo[b];
      end
    end
    @(negedge clk); rst = 1'b0;
    edges(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
